// File: rtl/io_regs_pkg.sv
// io_regs_pkg: register indices, blank glyph and byte-lane helpers for the
// io_regs bus peripheral.
package io_regs_pkg;

    localparam logic [3:0] IDX_LEDR      = 4'd0;
    localparam logic [3:0] IDX_HEX       = 4'd1;
    localparam logic [3:0] IDX_HEX_EN    = 4'd2;
    localparam logic [3:0] IDX_SW        = 4'd3;
    localparam logic [3:0] IDX_KEY       = 4'd4;
    localparam logic [3:0] IDX_KEY_EDGE  = 4'd5;
    localparam logic [3:0] IDX_TIMER     = 4'd6;
    localparam logic [3:0] IDX_TIMER_CMP = 4'd7;
    localparam logic [3:0] IDX_STATUS    = 4'd8;

    // All segments off (active-low).
    localparam logic [6:0] BLANK_GLYPH = 7'h7F;

    // Expand a 4-bit byte strobe into a 32-bit bit mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] strb);
        logic [31:0] mask;
        mask = 32'd0;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                mask[8*b +: 8] = 8'hFF;
            end else begin
                mask[8*b +: 8] = 8'h00;
            end
        end
        return mask;
    endfunction

    // Replace only the strobed byte lanes of old_val with new_val.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] mask;
        mask = lane_mask(strb);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/io_regs_hex7seg.sv
// hex7seg: combinational 4-bit to active-low 7-segment {g,f,e,d,c,b,a}
// decoder; a cleared enable shows a blank digit.
module hex7seg
    import io_regs_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       en,
    output logic [6:0] seg
);

    // Glyph lookup, forced blank when the digit is disabled.
    always_comb begin
        seg = BLANK_GLYPH;
        if (en) begin
            case (digit)
                4'h0:    seg = 7'h40;
                4'h1:    seg = 7'h79;
                4'h2:    seg = 7'h24;
                4'h3:    seg = 7'h30;
                4'h4:    seg = 7'h19;
                4'h5:    seg = 7'h12;
                4'h6:    seg = 7'h02;
                4'h7:    seg = 7'h78;
                4'h8:    seg = 7'h00;
                4'h9:    seg = 7'h10;
                4'hA:    seg = 7'h08;
                4'hB:    seg = 7'h03;
                4'hC:    seg = 7'h46;
                4'hD:    seg = 7'h21;
                4'hE:    seg = 7'h06;
                4'hF:    seg = 7'h0E;
                default: seg = BLANK_GLYPH;
            endcase
        end else begin
            seg = BLANK_GLYPH;
        end
    end

endmodule

// File: rtl/io_regs.sv
// io_regs: memory-mapped board I/O on the data bus -- LEDs, six 7-segment
// digits, synchronized switches/keys with sticky press flags, and a
// prescaled tick timer with a compare flag driving irq.
module io_regs
    import io_regs_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int TICK_HZ     = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sel,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    input  logic [9:0]  sw,
    input  logic [3:0]  key,
    output logic [9:0]  ledr,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic        irq
);

    localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

    logic [3:0]    idx_s;
    logic          rd_s;
    logic          wr_ledr_s;
    logic          wr_hex_s;
    logic          wr_hex_en_s;
    logic          wr_key_edge_s;
    logic          wr_timer_s;
    logic          wr_timer_cmp_s;
    logic          wr_status_s;
    logic [31:0]   rd_mux_s;
    logic          tick_s;
    logic [31:0]   timer_inc_s;
    logic          cmp_hit_s;
    logic          status_clr_s;
    logic [3:0]    key_edge_clr_s;
    logic [3:0]    key_edge_set_s;
    logic          unused_s;

    logic [9:0]    ledr_r;
    logic [23:0]   hex_r;
    logic [5:0]    hex_en_r;
    logic [9:0]    sw_meta_r;
    logic [9:0]    sw_sync_r;
    logic [3:0]    key_meta_r;
    logic [3:0]    key_sync_r;
    logic [3:0]    key_prev_r;
    logic [3:0]    key_edge_r;
    logic [31:0]   timer_r;
    logic [31:0]   timer_cmp_r;
    logic [PW-1:0] presc_r;
    logic          cmp_flag_r;
    logic [31:0]   rdata_r;
    logic          rdata_valid_r;
    logic [6:0]    hex_seg_s [6];

    assign idx_s    = addr[5:2];
    assign rd_s     = sel & ~we;
    assign unused_s = ^{addr[31:6], addr[1:0]};

    // Decode which register a bus write targets this cycle.
    always_comb begin
        wr_ledr_s      = 1'b0;
        wr_hex_s       = 1'b0;
        wr_hex_en_s    = 1'b0;
        wr_key_edge_s  = 1'b0;
        wr_timer_s     = 1'b0;
        wr_timer_cmp_s = 1'b0;
        wr_status_s    = 1'b0;
        if (sel && we) begin
            case (idx_s)
                IDX_LEDR:      wr_ledr_s      = 1'b1;
                IDX_HEX:       wr_hex_s       = 1'b1;
                IDX_HEX_EN:    wr_hex_en_s    = 1'b1;
                IDX_KEY_EDGE:  wr_key_edge_s  = 1'b1;
                IDX_TIMER:     wr_timer_s     = 1'b1;
                IDX_TIMER_CMP: wr_timer_cmp_s = 1'b1;
                IDX_STATUS:    wr_status_s    = 1'b1;
                default:       wr_ledr_s      = 1'b0;
            endcase
        end else begin
            wr_ledr_s = 1'b0;
        end
    end

    // Read data mux; unmapped indices and unused bits return zero.
    always_comb begin
        rd_mux_s = 32'd0;
        case (idx_s)
            IDX_LEDR:      rd_mux_s = {22'd0, ledr_r};
            IDX_HEX:       rd_mux_s = {8'd0, hex_r};
            IDX_HEX_EN:    rd_mux_s = {26'd0, hex_en_r};
            IDX_SW:        rd_mux_s = {22'd0, sw_sync_r};
            IDX_KEY:       rd_mux_s = {28'd0, key_sync_r};
            IDX_KEY_EDGE:  rd_mux_s = {28'd0, key_edge_r};
            IDX_TIMER:     rd_mux_s = timer_r;
            IDX_TIMER_CMP: rd_mux_s = timer_cmp_r;
            IDX_STATUS:    rd_mux_s = {31'd0, cmp_flag_r};
            default:       rd_mux_s = 32'd0;
        endcase
    end

    // Timer tick, compare detection and W1C/set terms for sticky flags.
    always_comb begin
        tick_s         = (presc_r == PRESC_LAST);
        timer_inc_s    = timer_r + 32'd1;
        // A load in the same cycle pre-empts both the tick and the compare.
        cmp_hit_s      = tick_s & ~wr_timer_s & (timer_inc_s == timer_cmp_r);
        status_clr_s   = wr_status_s & wstrb[0] & wdata[0];
        key_edge_clr_s = {4{wr_key_edge_s & wstrb[0]}} & wdata[3:0];
        key_edge_set_s = key_sync_r & ~key_prev_r;
    end

    // Read response register: one-cycle valid strobe, data held otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_r       <= 32'd0;
            rdata_valid_r <= 1'b0;
        end else begin
            rdata_valid_r <= rd_s;
            if (rd_s) begin
                rdata_r <= rd_mux_s;
            end
        end
    end

    // Writable display registers with per-byte strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ledr_r   <= 10'd0;
            hex_r    <= 24'd0;
            hex_en_r <= 6'd0;
        end else begin
            if (wr_ledr_s) begin
                ledr_r <= 10'(lane_merge({22'd0, ledr_r}, wdata, wstrb));
            end
            if (wr_hex_s) begin
                hex_r <= 24'(lane_merge({8'd0, hex_r}, wdata, wstrb));
            end
            if (wr_hex_en_s) begin
                hex_en_r <= 6'(lane_merge({26'd0, hex_en_r}, wdata, wstrb));
            end
        end
    end

    // Two-flop synchronizers for switches and inverted keys, plus edge history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_meta_r  <= 10'd0;
            sw_sync_r  <= 10'd0;
            key_meta_r <= 4'd0;
            key_sync_r <= 4'd0;
            key_prev_r <= 4'd0;
        end else begin
            sw_meta_r  <= sw;
            sw_sync_r  <= sw_meta_r;
            key_meta_r <= ~key;
            key_sync_r <= key_meta_r;
            key_prev_r <= key_sync_r;
        end
    end

    // Sticky key-press flags; a new press wins over a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_edge_r <= 4'd0;
        end else begin
            key_edge_r <= (key_edge_r & ~key_edge_clr_s) | key_edge_set_s;
        end
    end

    // Prescaler and tick counter; a bus load restarts the prescaler.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_r <= '0;
            timer_r <= 32'd0;
        end else if (wr_timer_s) begin
            presc_r <= '0;
            timer_r <= lane_merge(timer_r, wdata, wstrb);
        end else if (tick_s) begin
            presc_r <= '0;
            timer_r <= timer_inc_s;
        end else begin
            presc_r <= presc_r + PRESC_ONE;
        end
    end

    // Compare value register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_cmp_r <= 32'hFFFF_FFFF;
        end else if (wr_timer_cmp_s) begin
            timer_cmp_r <= lane_merge(timer_cmp_r, wdata, wstrb);
        end else begin
            timer_cmp_r <= timer_cmp_r;
        end
    end

    // Compare flag; a hit wins over a simultaneous W1C.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmp_flag_r <= 1'b0;
        end else if (cmp_hit_s) begin
            cmp_flag_r <= 1'b1;
        end else if (status_clr_s) begin
            cmp_flag_r <= 1'b0;
        end else begin
            cmp_flag_r <= cmp_flag_r;
        end
    end

    for (genvar n = 0; n < 6; n++) begin : g_hex
        hex7seg u_hex7seg (
            .digit (hex_r[4*n +: 4]),
            .en    (hex_en_r[n]),
            .seg   (hex_seg_s[n])
        );
    end

    assign hex0        = hex_seg_s[0];
    assign hex1        = hex_seg_s[1];
    assign hex2        = hex_seg_s[2];
    assign hex3        = hex_seg_s[3];
    assign hex4        = hex_seg_s[4];
    assign hex5        = hex_seg_s[5];
    assign ledr        = ledr_r;
    assign irq         = cmp_flag_r;
    assign rdata       = rdata_r;
    assign rdata_valid = rdata_valid_r;

endmodule
